bram_stream_loader: RTL and testbench
=====================================

# bram_stream_loader

Streaming writer for the multi-bank BRAM: accepts a stream of WIDTH-bit words and writes them round-robin across BANKS banks through each bank's port A (ena/wea/addra/dina), one bank per accepted word. Sits between a DMA/AXI-Stream source and the banked weight/coefficient memory, so that the consumers reading through port B see row r of every bank populated with consecutive stream words.

## Interface
- BANKS, 4, number of banks driven
- WIDTH, 16, data width per bank word
- DEPTH, 256, words per bank
- ADDR, $clog2(DEPTH), bank address width
- WE, WIDTH/8, byte-write-enable bits per bank

- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- start  in  1  begin a load; sampled only in IDLE
- base_addr  in  ADDR  first row address, captured on start
- length  in  ADDR+1  rows to write per bank, captured on start; 0 means empty load; values > DEPTH saturate to DEPTH
- s_axis_tdata  in  WIDTH  stream word
- s_axis_tvalid  in  1  stream valid
- s_axis_tready  out  1  stream ready
- s_axis_tlast  in  1  marks final word of the load
- ena  out  BANKS  port A enable, one bit per bank
- wea  out  BANKS*WE  port A byte write enables, WE bits per bank
- addra  out  BANKS*ADDR  port A address, ADDR bits per bank
- dina  out  BANKS*WIDTH  port A write data, WIDTH bits per bank
- busy  out  1  high from the cycle after accepted start until the done cycle
- done  out  1  one-cycle pulse at end of load
- err  out  1  sticky framing error; cleared on next accepted start

## Operation
- FSM: IDLE -> (start, length!=0) LOAD; IDLE -> (start, length==0) DONE; LOAD -> (last word accepted) DRAIN; DRAIN -> DONE; DONE -> IDLE.
- Word k of a load (k = 0 .. length*BANKS-1) goes to bank k mod BANKS, row (base_addr + k div BANKS) mod DEPTH; row address wraps at DEPTH.
- Counters: bank index (0..BANKS-1) and row offset; bank index wraps to 0 and row increments when bank index == BANKS-1.
- Write strobe: the selected bank gets ena=1 and all WE wea bits = 1; every other bank gets ena=0, wea=0. addra/dina of unselected banks hold their previous values.
- Framing: load ends on the earlier of (a) word length*BANKS-1 accepted or (b) tlast accepted. err is set if tlast arrives before the final word, or if the final word arrives without tlast. In both cases the load still completes normally through DRAIN/DONE.
- start while not IDLE is ignored; base_addr/length are not re-sampled.
- In IDLE, DRAIN, and DONE, no port A writes are issued.

## Timing
- s_axis_tready = 1 exactly when state == LOAD; combinational from state only, never from tvalid.
- Handshake at cycle t (tvalid & tready) -> ena/wea/addra/dina for that word valid in cycle t+1 (registered), for one cycle only.
- Back-to-back handshakes give one write per cycle, full throughput.
- Last handshake at t: state DRAIN in t+1 (final write on bus), done=1 and busy=0 in t+2, IDLE in t+3.
- length==0: start at t -> done pulse at t+2, with no tready and no writes.
- Reset values: ena=0, wea=0, addra=0, dina=0, s_axis_tready=0, busy=0, done=0, err=0, state IDLE, counters 0. Reset mid-load aborts immediately, with no further writes; the partially written rows are left as-is.

## Structure
- Shared package: FSM state encoding (IDLE, LOAD, DRAIN, DONE); no other shared types.
- One sub-module: bank_write_demux. It takes the registered bank index, row address, data, and strobe and drives the flattened ena/wea/addra/dina vectors, holding data in unselected lanes.

## Test plan
- BANKS=4, base_addr=0, length=2, 8 words 0x0001..0x0008 with tlast on the 8th -> bank0 rows0/1 = 1,5; bank3 rows0/1 = 4,8; done one pulse two cycles after the 8th handshake; err=0.
- Wrap: base_addr=255, length=2, DEPTH=256 -> words 0..3 written to row 255, words 4..7 to row 0.
- Early tlast on word 5 of 8 -> exactly 5 writes, err=1, done pulses; next start clears err.
- Missing tlast on the final word -> all 8 writes, err=1, no tready after the final word.
- tvalid toggled every other cycle, then length=0 start -> writes occur only on handshake cycles; for length=0, done two cycles after start with zero writes.
- rst asserted mid-LOAD after 3 words -> all outputs 0 immediately; a new start reloads correctly from base_addr.

Source files
------------

// File: rtl/bram_stream_loader_pkg.sv
// bram_stream_loader_pkg: loader FSM state encoding
package bram_stream_loader_pkg;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;
endpackage

// File: rtl/bram_stream_loader_if.sv
// bram_stream_loader_if: AXI-Stream word channel feeding the loader
interface bram_stream_loader_if #(parameter int WIDTH = 16);
  logic [WIDTH-1:0] tdata;
  logic tvalid;
  logic tready;
  logic tlast;
  modport master (output tdata, tvalid, tlast, input tready);
  modport slave (input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/bram_stream_loader_bank_write_demux.sv
// bram_stream_loader_bank_write_demux: registered one-hot port-A strobe, unselected lanes hold addr/data
module bram_stream_loader_bank_write_demux #(
  parameter int BANKS = 4,
  parameter int WIDTH = 16,
  parameter int ADDR = 8,
  parameter int WE = 2,
  parameter int BW = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_wr,
  input  logic [BW-1:0] i_bank,
  input  logic [ADDR-1:0] i_addr,
  input  logic [WIDTH-1:0] i_data,
  output logic [BANKS-1:0] o_ena,
  output logic [BANKS*WE-1:0] o_wea,
  output logic [BANKS*ADDR-1:0] o_addra,
  output logic [BANKS*WIDTH-1:0] o_dina
);
  logic [BANKS-1:0] r_ena, w_sel;
  logic [BANKS-1:0][WE-1:0] r_wea;
  logic [BANKS-1:0][ADDR-1:0] r_addra;
  logic [BANKS-1:0][WIDTH-1:0] r_dina;
  for (genvar i = 0; i < BANKS; i++) begin : g_sel
    assign w_sel[i] = i_wr && i_bank == BW'(i);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_ena <= '0;
      r_wea <= '0;
      r_addra <= '0;
      r_dina <= '0;
    end else begin
      r_ena <= w_sel;
      for (int b = 0; b < BANKS; b++) begin
        r_wea[b] <= {WE{w_sel[b]}};
        if (w_sel[b]) begin
          r_addra[b] <= i_addr;
          r_dina[b] <= i_data;
        end
      end
    end
  assign o_ena = r_ena;
  assign o_wea = r_wea;
  assign o_addra = r_addra;
  assign o_dina = r_dina;
endmodule

// File: rtl/bram_stream_loader.sv
// bram_stream_loader: writes a word stream round-robin across BANKS BRAM port-A lanes, one row per BANKS words
module bram_stream_loader
  import bram_stream_loader_pkg::*;
#(
  parameter int BANKS = 4,
  parameter int WIDTH = 16,
  parameter int DEPTH = 256,
  parameter int ADDR = $clog2(DEPTH),
  parameter int WE = WIDTH / 8
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic [ADDR-1:0] base_addr,
  input  logic [ADDR:0] length,
  bram_stream_loader_if.slave s_axis,
  output logic [BANKS-1:0] ena,
  output logic [BANKS*WE-1:0] wea,
  output logic [BANKS*ADDR-1:0] addra,
  output logic [BANKS*WIDTH-1:0] dina,
  output logic busy,
  output logic done,
  output logic err
);
  localparam int BW = BANKS > 1 ? $clog2(BANKS) : 1;
  localparam logic [ADDR:0] L_DEPTH = (ADDR+1)'(DEPTH);
  logic [1:0] r_state;
  logic [ADDR-1:0] r_base, r_row, w_addr;
  logic [ADDR:0] r_len, w_sum;
  logic [BW-1:0] r_bank;
  logic r_done, r_err, w_hs, w_last_bank, w_final, w_end;
  assign s_axis.tready = r_state == S_LOAD;
  assign w_hs = s_axis.tvalid & s_axis.tready;
  assign w_last_bank = r_bank == BW'(BANKS - 1);
  assign w_final = w_last_bank && {1'b0, r_row} == r_len - 1'b1;
  assign w_end = w_hs & (w_final | s_axis.tlast);
  assign w_sum = {1'b0, r_base} + {1'b0, r_row};
  assign w_addr = ADDR'(w_sum >= L_DEPTH ? w_sum - L_DEPTH : w_sum);
  assign busy = r_state != S_IDLE && !r_done;
  assign done = r_done;
  assign err = r_err;
  // an empty load lingers one extra cycle in DONE so done lands two cycles after start
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= S_IDLE;
      r_base <= '0;
      r_len <= '0;
      r_row <= '0;
      r_bank <= '0;
      r_done <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_done <= r_state == S_DRAIN || (r_state == S_DONE && r_len == '0 && !r_done);
      case (r_state)
        S_IDLE: if (start) begin
          r_state <= length == '0 ? S_DONE : S_LOAD;
          r_base <= base_addr;
          r_len <= length > L_DEPTH ? L_DEPTH : length;
          r_row <= '0;
          r_bank <= '0;
          r_err <= 1'b0;
        end
        S_LOAD: if (w_hs) begin
          r_bank <= w_last_bank ? '0 : r_bank + 1'b1;
          r_row <= w_last_bank ? r_row + 1'b1 : r_row;
          if (s_axis.tlast != w_final) r_err <= 1'b1;
          if (w_end) r_state <= S_DRAIN;
        end
        S_DRAIN: r_state <= S_DONE;
        default: if (r_done) r_state <= S_IDLE;
      endcase
    end
  bram_stream_loader_bank_write_demux #(
    .BANKS(BANKS), .WIDTH(WIDTH), .ADDR(ADDR), .WE(WE), .BW(BW)
  ) u_demux (
    .clk(clk),
    .rst(rst),
    .i_wr(w_hs),
    .i_bank(r_bank),
    .i_addr(w_addr),
    .i_data(s_axis.tdata),
    .o_ena(ena),
    .o_wea(wea),
    .o_addra(addra),
    .o_dina(dina)
  );
endmodule

// File: tb/tb_bram_stream_loader.sv
// tb_bram_stream_loader: scenario table, reset-abort sequence and random loads against a word-index model
module tb_bram_stream_loader;
  localparam int BANKS = 4, WIDTH = 16, DEPTH = 256, ADDR = 8, WE = 2;
  logic clk = 0, rst = 1, start = 0;
  logic [ADDR-1:0] base_addr = '0;
  logic [ADDR:0] length = '0;
  logic [BANKS-1:0] ena;
  logic [BANKS*WE-1:0] wea;
  logic [BANKS*ADDR-1:0] addra;
  logic [BANKS*WIDTH-1:0] dina;
  logic busy, done, err;
  int n_chk = 0, n_err = 0;
  int got_mem [BANKS][DEPTH];
  typedef struct { int base; int len; int tlast_at; int vmode; int exp_wr; int exp_err; } vec_t;
  vec_t vecs [7];
  bram_stream_loader_if #(.WIDTH(WIDTH)) s_axis ();
  bram_stream_loader #(.BANKS(BANKS), .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR(ADDR), .WE(WE)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
    .s_axis(s_axis), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
    .busy(busy), .done(done), .err(err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_quiet(input string tag);
    chk({tag, "_ena"}, ena, 0);
    chk({tag, "_wea"}, wea, 0);
    chk({tag, "_tready"}, s_axis.tready, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask
  // Word k -> bank k%BANKS, row (base + k/BANKS)%DEPTH; write visible the cycle after its handshake.
  task automatic run_load(input int base, input int len, input int tlast_at, input int vmode,
                          input int dmode, output int nwr, output int m_err);
    int n, k, t, t_done, pb, pr, pd;
    bit loading, hs, hs_prev, v;
    n = (len > DEPTH ? DEPTH : len) * BANKS;
    k = 0; t_done = -1; hs_prev = 0; m_err = 0; nwr = 0; pb = 0; pr = 0; pd = 0;
    start = 1; base_addr = ADDR'(base); length = (ADDR+1)'(len);
    s_axis.tvalid = 0; s_axis.tlast = 0;
    tick();
    start = 0;
    loading = n != 0;
    if (!loading) t_done = 2;
    for (t = 1; t <= 3000; t++) begin
      chk("tready", s_axis.tready, loading);
      chk("busy", busy, t_done < 0 || t < t_done);
      chk("done", done, t == t_done);
      chk("err", err, m_err);
      chk("ena", ena, hs_prev ? 1 << pb : 0);
      chk("wea", wea, hs_prev ? ((1 << WE) - 1) << (WE * pb) : 0);
      if (hs_prev) begin
        chk("addra", addra[pb*ADDR +: ADDR], pr);
        chk("dina", dina[pb*WIDTH +: WIDTH], pd);
      end
      for (int b = 0; b < BANKS; b++)
        if (ena[b]) begin
          got_mem[b][addra[b*ADDR +: ADDR]] = int'(dina[b*WIDTH +: WIDTH]);
          nwr++;
        end
      if (t == t_done) break;
      v = vmode == 0 ? 1'b1 : vmode == 1 ? (t % 2 == 1) : 1'($urandom_range(0, 1));
      s_axis.tvalid = v;
      s_axis.tdata = dmode == 0 ? WIDTH'(k + 1) : WIDTH'($urandom);
      s_axis.tlast = v && k == tlast_at;
      start = 1'($urandom_range(0, 1));
      base_addr = ADDR'($urandom);
      length = (ADDR+1)'($urandom);
      hs = loading && v;
      if (hs) begin
        pb = k % BANKS;
        pr = (base + k / BANKS) % DEPTH;
        pd = int'(s_axis.tdata);
        if ((k == tlast_at) != (k == n - 1)) m_err = 1;
        if (k == tlast_at || k == n - 1) begin
          loading = 0;
          t_done = t + 2;
        end
        k++;
      end
      hs_prev = hs;
      tick();
    end
    if (t > 3000) chk("timeout", 1, 0);
    start = 0; s_axis.tvalid = 0; s_axis.tlast = 0;
    tick();
    chk_quiet("idle");
    chk("idle_err", err, m_err);
  endtask
  initial begin
    int nwr, e, n, sel, ta, ln;
    s_axis.tvalid = 0; s_axis.tlast = 0; s_axis.tdata = '0;
    vecs[0] = '{0, 2, 7, 0, 8, 0};
    vecs[1] = '{255, 2, 7, 0, 8, 0};
    vecs[2] = '{0, 2, 4, 0, 5, 1};
    vecs[3] = '{40, 3, 11, 1, 12, 0};
    vecs[4] = '{3, 2, -1, 0, 8, 1};
    vecs[5] = '{7, 0, -1, 1, 0, 0};
    vecs[6] = '{0, 300, 1023, 0, 1024, 0};
    #1;
    chk_quiet("rst");
    chk("rst_err", err, 0);
    chk("rst_addra", addra, 0);
    chk("rst_dina", dina, 0);
    #21 rst = 0;
    tick();
    for (int i = 0; i < 7; i++) begin
      run_load(vecs[i].base, vecs[i].len, vecs[i].tlast_at, vecs[i].vmode, 0, nwr, e);
      chk($sformatf("vec%0d_writes", i), nwr, vecs[i].exp_wr);
      chk($sformatf("vec%0d_err", i), e, vecs[i].exp_err);
      if (i == 0) begin
        chk("mem_b0r0", got_mem[0][0], 1);
        chk("mem_b0r1", got_mem[0][1], 5);
        chk("mem_b3r0", got_mem[3][0], 4);
        chk("mem_b3r1", got_mem[3][1], 8);
      end
      if (i == 1) begin
        chk("wrap_b0r255", got_mem[0][255], 1);
        chk("wrap_b3r255", got_mem[3][255], 4);
        chk("wrap_b0r0", got_mem[0][0], 5);
        chk("wrap_b3r0", got_mem[3][0], 8);
      end
    end
    start = 1; base_addr = 10; length = 3;
    tick();
    start = 0; s_axis.tvalid = 1; s_axis.tlast = 0;
    for (int i = 0; i < 3; i++) begin
      s_axis.tdata = WIDTH'(16'h100 + i);
      tick();
    end
    chk("mid_ena", ena, 4'b0100);
    chk("mid_dina", dina[2*WIDTH +: WIDTH], 16'h102);
    rst = 1;
    #1;
    chk_quiet("abort");
    chk("abort_err", err, 0);
    chk("abort_addra", addra, 0);
    chk("abort_dina", dina, 0);
    s_axis.tvalid = 0;
    #2 rst = 0;
    tick();
    chk_quiet("post_rst");
    run_load(10, 2, 7, 0, 0, nwr, e);
    chk("reload_writes", nwr, 8);
    chk("reload_b0r10", got_mem[0][10], 1);
    chk("reload_b1r10", got_mem[1][10], 2);
    chk("reload_b0r11", got_mem[0][11], 5);
    for (int i = 0; i < 25; i++) begin
      ln = int'($urandom_range(0, 5));
      n = ln * BANKS;
      sel = int'($urandom_range(0, 2));
      ta = sel == 0 ? n - 1 : (sel == 1 && n > 0) ? int'($urandom_range(0, n - 1)) : -1;
      run_load(int'($urandom_range(0, DEPTH - 1)), ln, ta, 2, 1, nwr, e);
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
